regfile_write_ctrl: RTL and testbench
=====================================

# regfile_write_ctrl

Write-port controller for the 32x32 register file in the 5-stage pipeline. It shares the single register-file write port between the WB stage and a long-latency result source (mult/div HI/LO mover, memory return) through a small pending queue, with an age-based stall to prevent starvation. It also runs a post-reset sweep that clears registers 1..31. A read-after-write hazard flag tells decode when a source register still has a queued write.

## Interface
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- QDEPTH, 2, pending-queue entries (power of 2, ≥2)
- AGE_MAX, 4, cycles a queue head may wait before forcing a WB stall

- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  WB stage write request
- wb_reg  in  ADDR_W  WB destination
- wb_data  in  DATA_W  WB data
- lu_valid  in  1  long-latency result valid
- lu_reg  in  ADDR_W  long-latency destination
- lu_data  in  DATA_W  long-latency data
- lu_ready  out  1  queue can accept (combinational)
- rd_reg_1, rd_reg_2  in  ADDR_W  decode source registers
- hazard  out  1  a source matches a queued destination (combinational)
- stall_req  out  1  WB must hold its request this cycle (combinational)
- init_busy  out  1  clearing sweep in progress
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)

## Operation
- States: INIT, RUN. Reset enters INIT with ptr=1, queue empty, count=0, age=0, and rf_we/rf_waddr/rf_wdata=0.
- INIT: each cycle issue rf_we=1, rf_waddr=ptr, rf_wdata=0, then ptr++. The cycle that issues ptr=31 moves to RUN. wb_valid is ignored; lu_ready=0; stall_req=0.
- init_busy=1 iff state==INIT. The pipeline is held by init_busy.
- RUN, per-cycle issue priority:
  1. If stall_req: issue the queue head and pop it. The WB request is not taken; WB re-presents it next cycle.
  2. Else if wb_valid and wb_reg≠0: issue WB.
  3. Else if the queue is non-empty: issue the head and pop it.
  4. Else rf_we=0.
- WB writes to register 0 are discarded and do not consume the slot, so the queue may issue in that cycle.
- Enqueue on lu_valid && lu_ready at posedge. lu_reg=0 is handshaken but not stored.
- lu_ready = (state==RUN) && (count<QDEPTH). A pop in the same cycle does not raise lu_ready.
- Simultaneous pop and enqueue: count is unchanged; the FIFO is circular and pointers wrap mod QDEPTH.
- age: 0 when the queue is empty or on a pop; otherwise +1 per cycle, saturating at AGE_MAX.
- stall_req = (state==RUN) && count≠0 && age≥AGE_MAX.
- hazard = OR over valid entries of (entry.reg==rd_reg_1 && rd_reg_1≠0) or (entry.reg==rd_reg_2 && rd_reg_2≠0). Decode stalls while hazard is high, which preserves program order between queued and WB writes to the same register.
- Same-cycle WB and enqueue to the same register: WB issues first, the queued write lands later. Decode's hazard stall covers ordering.

## Timing
- Request sampled at posedge N → rf_* valid during cycle N+1. The register file captures at the negedge of cycle N+1.
- WB latency: 1 cycle when not stalled.
- Queue latency: minimum 2 cycles (enqueue at N, issue sampled at N+1, rf_we in N+2). Maximum AGE_MAX+2 cycles for the head.
- INIT takes 31 cycles after rst_n rises. rf_we is high for exactly those 31 cycles. The first RUN request is sampled on the cycle after the ptr=31 issue.
- rst_n low at any time, asynchronously: state INIT, queue flushed, all registered outputs 0, lu_ready=0, stall_req=0, hazard=0. Queued writes are lost.
- Outputs: rf_* registered; init_busy decoded from the state register; lu_ready, stall_req and hazard are combinational from registered state plus the rd_reg inputs (no input-to-output path except via rd_reg).

## Test plan
- Reset release → 31 consecutive rf_we pulses with rf_waddr 1..31 and rf_wdata=0. init_busy falls after the pulse with waddr=31. lu_ready=0 throughout.
- RUN, wb_valid with reg 7, data 0x4 → rf_we=1, rf_waddr=7, rf_wdata=4 one cycle later. wb_reg=0, data 5 → rf_we stays 0.
- lu enqueue (reg 2, 0x0A) and (reg 1, 0x03), no WB traffic → issued in order at N+2 and N+3. hazard=1 for rd_reg_1=2 until that entry pops.
- Queue full (2 entries): lu_ready=0. A third lu_valid is held and not lost. It is accepted the cycle after a pop.
- Continuous wb_valid to reg 9 with one entry queued (reg 3) → stall_req rises after 4 waiting cycles. Reg 3 issues that cycle. WB's held write to reg 9 issues the next cycle.
- rst_n pulsed low with 2 entries queued → count=0, rf_we=0 immediately. The sweep restarts at reg 1, and neither queued entry is ever written.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// Register-file write-port arbiter: WB stage vs. long-latency results, with a post-reset clearing sweep.
// Latency: WB 1 cycle; queued results 2..AGE_MAX+2 cycles; sweep occupies 31 cycles after reset.
// Backpressure: lu_ready low when the queue is full or sweeping; stall_req holds WB when the queue head is too old.
`timescale 1ns/1ps
module regfile_write_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int QDEPTH  = 2,
  parameter int AGE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_reg,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] rd_reg_1,
  input  logic [ADDR_W-1:0] rd_reg_2,
  output logic              hazard,
  output logic              stall_req,
  output logic              init_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = $clog2(AGE_MAX + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] q_reg_q [QDEPTH];
  logic [DATA_W-1:0] q_dat_q [QDEPTH];
  logic [QDEPTH-1:0] q_vld_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     age_q, age_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic q_empty;
  logic wb_take;
  logic enq;
  logic pop;
  logic hazard_c;

  assign q_empty   = (count_q == '0);
  assign wb_take   = wb_valid && (wb_reg != '0);
  assign lu_ready  = (state_q == ST_RUN) && (count_q < CW'(QDEPTH));
  assign stall_req = (state_q == ST_RUN) && !q_empty && (age_q >= AW'(AGE_MAX));
  // Writes to r0 complete the handshake but never occupy a slot.
  assign enq       = lu_valid && lu_ready && (lu_reg != '0);
  assign init_busy = (state_q == ST_INIT);
  assign hazard    = hazard_c;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

  // Sweep sequencing and write-port issue priority: aged queue head, then WB, then queue head.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    pop        = 1'b0;
    case (state_q)
      ST_INIT: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = ptr_q;
        ptr_d      = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall_req) begin
          pop = 1'b1;
        end else if (wb_take) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = wb_reg;
          rf_wdata_d = wb_data;
        end else if (!q_empty) begin
          pop = 1'b1;
        end
        if (pop) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = q_reg_q[rd_ptr_q];
          rf_wdata_d = q_dat_q[rd_ptr_q];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Occupancy and head-age bookkeeping; age restarts whenever the head changes or the queue is empty.
  always_comb begin
    count_d = count_q;
    if (enq && !pop)      count_d = count_q + CW'(1);
    else if (!enq && pop) count_d = count_q - CW'(1);
    age_d = age_q;
    if (pop || q_empty)             age_d = '0;
    else if (age_q < AW'(AGE_MAX))  age_d = age_q + AW'(1);
  end

  // Decode hazard: any live queue entry targeting a nonzero source register.
  always_comb begin
    hazard_c = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld_q[i] &&
          (((q_reg_q[i] == rd_reg_1) && (rd_reg_1 != '0)) ||
           ((q_reg_q[i] == rd_reg_2) && (rd_reg_2 != '0)))) begin
        hazard_c = 1'b1;
      end
    end
  end

  // Control state, registered write port and circular pending queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= ADDR_W'(1);
      count_q    <= '0;
      age_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      q_vld_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_reg_q[i] <= '0;
        q_dat_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      if (pop) begin
        q_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (enq) begin
        q_vld_q[wr_ptr_q] <= 1'b1;
        q_reg_q[wr_ptr_q] <= lu_reg;
        q_dat_q[wr_ptr_q] <= lu_data;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl with a cycle-stamped write scoreboard.
// Latency: expected writes carry the cycle in which rf_we must be seen.
// Backpressure: exercises full queue, aged-head stall and reset flush.
`timescale 1ns/1ps
module tb_regfile_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_reg;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rd_reg_1, rd_reg_2;
  logic        hazard, stall_req, init_busy, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          c;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  regfile_write_ctrl #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2), .AGE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2), .hazard(hazard),
    .stall_req(stall_req), .init_busy(init_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.c = c;
    e.r = r;
    e.d = d;
    sb.push_back(e);
  endtask

  // Every register-file write must match an expected entry stamped with this cycle.
  always @(negedge clk) begin
    int idx;
    idx = -1;
    if (rst_n && rf_we) begin
      foreach (sb[i]) if (idx < 0 && sb[i].c == cyc) idx = i;
      if (idx < 0) begin
        chk("unexpected_we", {31'd0, rf_we}, 32'd0);
      end else begin
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, sb[idx].r});
        chk("wr_data", rf_wdata, sb[idx].d);
        sb.delete(idx);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, c;
    rst_n = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    lu_valid = 1'b0; lu_reg = '0; lu_data = '0; rd_reg_1 = 5'd5; rd_reg_2 = '0;
    repeat (3) step();

    // Reset state
    chk("rst_we",     {31'd0, rf_we}, 32'd0);
    chk("rst_waddr",  {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata",  rf_wdata, 32'd0);
    chk("rst_busy",   {31'd0, init_busy}, 32'd1);
    chk("rst_ready",  {31'd0, lu_ready}, 32'd0);
    chk("rst_stall",  {31'd0, stall_req}, 32'd0);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);

    // Clearing sweep: r1..r31 written with zero on consecutive cycles
    rel = cyc;
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) push(rel + i, 5'(i), 32'd0);
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      chk("sweep_busy",  {31'd0, init_busy}, 32'd1);
      chk("sweep_ready", {31'd0, lu_ready}, 32'd0);
    end
    step();
    step();
    chk("run_busy",  {31'd0, init_busy}, 32'd0);
    chk("run_ready", {31'd0, lu_ready}, 32'd1);

    // WB write, WB write to r0 discarded, lu write to r0 not stored
    c = cyc;
    wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'h4;
    push(c + 1, 5'd7, 32'h4);
    step();
    wb_reg = 5'd0; wb_data = 32'h5;
    step();
    wb_valid = 1'b0;
    lu_valid = 1'b1; lu_reg = 5'd0; lu_data = 32'h77;
    chk("r0_ready", {31'd0, lu_ready}, 32'd1);
    @(negedge clk);
    chk("wb_r0_no_we", {31'd0, rf_we}, 32'd0);
    step();
    lu_valid = 1'b0;
    step();
    @(negedge clk);
    chk("lu_r0_no_we", {31'd0, rf_we}, 32'd0);

    // Two queued results issue in order; hazard tracks the live entries
    step();
    c = cyc;
    rd_reg_1 = 5'd2; rd_reg_2 = 5'd0;
    lu_valid = 1'b1; lu_reg = 5'd2; lu_data = 32'h0A;
    push(c + 2, 5'd2, 32'h0A);
    step();
    lu_reg = 5'd1; lu_data = 32'h03;
    push(c + 3, 5'd1, 32'h03);
    chk("q1_ready", {31'd0, lu_ready}, 32'd1);
    @(negedge clk);
    chk("hazard_r2_set", {31'd0, hazard}, 32'd1);
    step();
    lu_valid = 1'b0;
    @(negedge clk);
    chk("hazard_r2_clr", {31'd0, hazard}, 32'd0);
    rd_reg_2 = 5'd1;
    #1;
    chk("hazard_r1_src2", {31'd0, hazard}, 32'd1);
    rd_reg_2 = 5'd0;
    step();
    step();
    rd_reg_1 = 5'd0;

    // Full queue: third request held until a pop frees a slot
    step();
    c = cyc;
    wb_valid = 1'b1; wb_reg = 5'd10; wb_data = 32'h100;
    lu_valid = 1'b1; lu_reg = 5'd4; lu_data = 32'h44;
    push(c + 1, 5'd10, 32'h100);
    step();
    wb_data = 32'h101; push(c + 2, 5'd10, 32'h101);
    lu_reg = 5'd5; lu_data = 32'h55;
    chk("full_ready1", {31'd0, lu_ready}, 32'd1);
    step();
    wb_data = 32'h102; push(c + 3, 5'd10, 32'h102);
    lu_reg = 5'd6; lu_data = 32'h66;
    chk("full_ready0", {31'd0, lu_ready}, 32'd0);
    step();
    wb_data = 32'h103; push(c + 4, 5'd10, 32'h103);
    chk("full_hold_ready", {31'd0, lu_ready}, 32'd0);
    chk("full_no_stall", {31'd0, stall_req}, 32'd0);
    step();
    wb_valid = 1'b0;
    push(c + 5, 5'd4, 32'h44);
    push(c + 6, 5'd5, 32'h55);
    push(c + 7, 5'd6, 32'h66);
    chk("full_still0", {31'd0, lu_ready}, 32'd0);
    step();
    chk("ready_after_pop", {31'd0, lu_ready}, 32'd1);
    step();
    lu_valid = 1'b0;
    step();
    step();

    // Aged head forces a WB stall; held WB write issues the cycle after
    c = cyc;
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h900;
    lu_valid = 1'b1; lu_reg = 5'd3; lu_data = 32'h33;
    push(c + 1, 5'd9, 32'h900);
    for (int k = 1; k <= 4; k++) begin
      step();
      lu_valid = 1'b0;
      wb_data = 32'h900 + 32'(k);
      push(cyc + 1, 5'd9, 32'h900 + 32'(k));
      chk("stall_low", {31'd0, stall_req}, 32'd0);
    end
    step();
    chk("stall_rise", {31'd0, stall_req}, 32'd1);
    wb_data = 32'h905;
    push(c + 6, 5'd3, 32'h33);
    push(c + 7, 5'd9, 32'h905);
    step();
    chk("stall_fall", {31'd0, stall_req}, 32'd0);
    step();
    wb_valid = 1'b0;
    step();
    step();

    // Reset with two entries queued: nothing queued is ever written
    c = cyc;
    wb_valid = 1'b1; wb_reg = 5'd11; wb_data = 32'h110;
    lu_valid = 1'b1; lu_reg = 5'd12; lu_data = 32'h0C;
    push(c + 1, 5'd11, 32'h110);
    rd_reg_1 = 5'd12;
    step();
    wb_data = 32'h111; push(c + 2, 5'd11, 32'h111);
    lu_reg = 5'd13; lu_data = 32'h0D;
    step();
    wb_valid = 1'b0; lu_valid = 1'b0;
    chk("pre_rst_hazard", {31'd0, hazard}, 32'd1);
    chk("pre_rst_ready", {31'd0, lu_ready}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_we",     {31'd0, rf_we}, 32'd0);
    chk("arst_waddr",  {27'd0, rf_waddr}, 32'd0);
    chk("arst_ready",  {31'd0, lu_ready}, 32'd0);
    chk("arst_stall",  {31'd0, stall_req}, 32'd0);
    chk("arst_hazard", {31'd0, hazard}, 32'd0);
    chk("arst_busy",   {31'd0, init_busy}, 32'd1);
    repeat (2) step();
    rel = cyc;
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) push(rel + i, 5'(i), 32'd0);
    repeat (33) step();
    chk("resweep_done", {31'd0, init_busy}, 32'd0);
    chk("flushed_hazard", {31'd0, hazard}, 32'd0);
    repeat (5) step();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
